// File: rtl/tree_seq_pkg.sv
// Shared constants for tree_seq: FSM state encoding, gate operator codes and
// the level-to-operator mapping of the alternating OR/AND reduction tree.
package tree_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_OR  = 1'b0;
    localparam logic OP_AND = 1'b1;

    // Operator of level k: OR when (levels-k) is odd, AND when it is even.
    function automatic logic level_op(input int unsigned levels, input int unsigned k);
        return (((levels - k) % 32'd2) == 32'd1) ? OP_OR : OP_AND;
    endfunction

endpackage

// File: rtl/tree_seq_alu.sv
// Single shared 1-bit gate of the reduction tree (OR or AND selected by op).
module tree_seq_alu
    import tree_seq_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic op,
    output logic c
);

    // Purely combinational gate.
    always_comb begin
        c = (op == OP_AND) ? (a & b) : (a | b);
    end

endmodule

// File: rtl/tree_seq.sv
// Sequential evaluator of an alternating OR/AND reduction tree over x,y using
// one shared gate, one gate evaluation per clock (2*GATES_NO-1 gates total).
// Optional feature: define TREE_SEQ_ABORT_EN to add an abort input that
// cancels an evaluation in progress without a done pulse.
module tree_seq
    import tree_seq_pkg::*;
#(
    parameter int unsigned LEVELS   = 5,
    parameter int unsigned GATES_NO = 2 ** (LEVELS - 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef TREE_SEQ_ABORT_EN
    input  logic                abort,
`endif
    input  logic [GATES_NO-1:0] x,
    input  logic [GATES_NO-1:0] y,
    output logic                busy,
    output logic                done,
    output logic                z
);

    localparam int unsigned IW = (GATES_NO > 1) ? $clog2(GATES_NO) : 1;
    localparam int unsigned LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                capture_c;
    logic                step_c;
    logic                load_z_c;
    logic                last_c;
    logic                abort_c;

    logic [GATES_NO-1:0] x_reg;
    logic [GATES_NO-1:0] y_reg;
    logic [GATES_NO-1:0] tbuf;
    logic [LW-1:0]       level;
    logic [IW-1:0]       index;
    logic [IW-1:0]       last_idx_c;
    logic [IW-1:0]       idx_lo_c;
    logic [IW-1:0]       idx_hi_c;
    logic                a_c;
    logic                b_c;
    logic                op_c;
    logic                gate_c;

`ifdef TREE_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Position bookkeeping: last gate of the current level and of the whole tree.
    always_comb begin
        last_idx_c = IW'((GATES_NO >> level) - 1);
        last_c     = (level == LW'(LEVELS - 1)) && (index == '0);
        idx_lo_c   = {index[IW-2:0], 1'b0};
        idx_hi_c   = {index[IW-2:0], 1'b1};
    end

    // Gate operand selection: captured operands at level 0, buffer pairs after.
    always_comb begin
        op_c = level_op(LEVELS, 32'(level));
        if (level == '0) begin
            a_c = x_reg[index];
            b_c = y_reg[index];
        end else begin
            a_c = tbuf[idx_lo_c];
            b_c = tbuf[idx_hi_c];
        end
    end

    tree_seq_alu u_alu (
        .a  (a_c),
        .b  (b_c),
        .op (op_c),
        .c  (gate_c)
    );

    // State register with registered busy/done decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        step_c    = 1'b0;
        load_z_c  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    capture_c = 1'b1;
                    state_nxt = ST_EVAL;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (abort_c) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step_c = 1'b1;
                    if (last_c) begin
                        load_z_c  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt == ST_EVAL);
        done_nxt = (state_nxt == ST_DONE);
    end

    // Datapath: operand capture, in-place buffer update, counters and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
            tbuf  <= '0;
            level <= '0;
            index <= '0;
            z     <= 1'b0;
        end else begin
            if (capture_c) begin
                x_reg <= x;
                y_reg <= y;
                level <= '0;
                index <= '0;
            end else if (step_c) begin
                tbuf[index] <= gate_c;
                if (!last_c) begin
                    if (index == last_idx_c) begin
                        level <= level + LW'(1);
                        index <= '0;
                    end else begin
                        index <= index + IW'(1);
                    end
                end
            end
            if (load_z_c) begin
                z <= gate_c;
            end
        end
    end

endmodule

// File: tb/tb_tree_seq.sv
// Randomized self-checking bench for tree_seq (LEVELS=5, 16-bit operands).
module tb_tree_seq;

    localparam int L = 5;
    localparam int G = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
`ifdef TREE_SEQ_ABORT_EN
    logic         abort;
`endif
    logic [G-1:0] x;
    logic [G-1:0] y;
    logic         busy;
    logic         done;
    logic         z;

    int n_checks = 0;
    int n_pass   = 0;

    tree_seq #(.LEVELS(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef TREE_SEQ_ABORT_EN
        .abort (abort),
`endif
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // 1 = AND, 0 = OR for level k.
    function automatic logic is_and(input int k);
        return ((L - k) % 2) == 0;
    endfunction

    // Whole-tree result computed level by level with fresh arrays.
    function automatic logic model(input logic [G-1:0] a, input logic [G-1:0] b);
        logic v [G];
        logic t [G];
        int   n;
        for (int i = 0; i < G; i++) v[i] = is_and(0) ? (a[i] & b[i]) : (a[i] | b[i]);
        n = G;
        for (int k = 1; k < L; k++) begin
            n = n / 2;
            for (int i = 0; i < n; i++)
                t[i] = is_and(k) ? (v[2*i] & v[2*i+1]) : (v[2*i] | v[2*i+1]);
            for (int i = 0; i < n; i++) v[i] = t[i];
        end
        return v[0];
    endfunction

    // Drive start now (just after an edge) and follow the run to done.
    task automatic run_one(input logic [G-1:0] a, input logic [G-1:0] b, input string tag);
        int   lat;
        int   bc;
        logic seen;
        logic exp;
        exp   = model(a, b);
        x     = a;
        y     = b;
        start = 1'b1;
        lat   = 0;
        bc    = 0;
        seen  = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                check({tag, "_busy_first"}, 32'(busy), 32'd1);
            end
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd32);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd31);
        check({tag, "_z"}, 32'(z), 32'(exp));
    endtask

    // One idle edge after a done: pulse must have ended.
    task automatic step_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   dn;
        int   first;
        logic zz;
        logic exp;
        logic [G-1:0] ra;
        logic [G-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
`ifdef TREE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        rst_n = 1'b1;

        // Start accepted on the first edge after reset release.
        run_one(16'hFFFF, 16'h0000, "all_ones");
        step_idle("all_ones");
        run_one(16'h000F, 16'h0000, "low_nibble");
        step_idle("low_nibble");
        run_one(16'h00FF, 16'h0000, "low_byte");

        // Back-to-back: restart straight out of DONE.
        run_one(16'h0000, 16'h0003, "b2b_a");
        run_one(16'h00F0, 16'h0F00, "b2b_b");
        step_idle("b2b");

        // Start and operand changes during EVAL are ignored.
        x     = 16'h0F0F;
        y     = 16'h0000;
        exp   = model(16'h0F0F, 16'h0000);
        start = 1'b1;
        lat   = 0;
        dn    = 0;
        first = 0;
        zz    = 1'b0;
        while (lat < 70) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat <= 20) begin
                start = 1'b1;
                x     = G'($urandom);
                y     = G'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dn++;
                if (first == 0) begin
                    first = lat;
                    zz    = z;
                end
            end
        end
        check("mid_start_done_count", 32'(dn), 32'd1);
        check("mid_start_latency", 32'(first), 32'd32);
        check("mid_start_z", 32'(zz), 32'(exp));

        // Randomized operands with sparse and dense bit patterns.
        for (int r = 0; r < 10; r++) begin
            ra = G'($urandom);
            rb = G'($urandom);
            if (r % 2 == 0) begin
                ra = ra & G'($urandom) & G'($urandom);
                rb = rb & G'($urandom) & G'($urandom);
            end
            run_one(ra, rb, "random");
            repeat ($urandom_range(0, 2)) step_idle("random");
        end
        step_idle("random_end");

        // Reset in the middle of EVAL.
        run_one(16'hFFFF, 16'h0000, "pre_reset");
        step_idle("pre_reset");
        x     = 16'hFFFF;
        y     = 16'h0000;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

`ifdef TREE_SEQ_ABORT_EN
        // Abort during EVAL keeps the earlier result and gives no done.
        run_one(16'hFFFF, 16'h0000, "pre_abort");
        step_idle("pre_abort");
        x     = 16'h0000;
        y     = 16'h0000;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_z", 32'(z), 32'd1);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_z_hold", 32'(z), 32'd1);
`endif

        // Normal operation resumes afterwards.
        run_one(16'h00FF, 16'h0000, "post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tree_seq.md
TREE_SEQ -- requirements
Module: tree_seq

Interface
- REQ-001 SHALL have parameter LEVELS, default 5: number of reduction levels.
- REQ-002 SHALL have parameter GATES_NO, default 2**(LEVELS-1): operand width and first-level gate count.
- REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port start, input, 1: request evaluation of x,y.
- REQ-006 SHALL have port x, input, GATES_NO: first operand vector.
- REQ-007 SHALL have port y, input, GATES_NO: second operand vector.
- REQ-008 SHALL have port busy, output, 1: evaluation in progress.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse when z is updated.
- REQ-010 SHALL have port z, output, 1: registered tree result.

Function
- REQ-011 SHALL evaluate the alternating OR/AND reduction tree with one shared 1-bit gate, one gate evaluation per clock.
- REQ-012 SHALL use this operator at level k (k=0 first, k=LEVELS-1 last): OR if (LEVELS-k) is odd, AND if (LEVELS-k) is even.
- REQ-013 SHALL compute level 0 as buf[i]=op(x_reg[i],y_reg[i]) for i=0..GATES_NO-1.
- REQ-014 SHALL compute level k>=1 in place as buf[i]=op(buf[2i],buf[2i+1]) for i=0..(GATES_NO>>k)-1, with i ascending.
- REQ-015 SHALL implement states IDLE, EVAL and DONE.
- REQ-016 SHALL, in IDLE or DONE with start=1, capture x,y into x_reg,y_reg, clear level/index counters and enter EVAL.
- REQ-017 SHALL, in EVAL, perform one gate evaluation per cycle and enter DONE after the final gate (level LEVELS-1, index 0); total 2*GATES_NO-1 EVAL cycles.
- REQ-018 SHALL load z from the final gate result on the EVAL->DONE edge and hold z until the next DONE entry.
- REQ-019 SHALL assert done only in DONE and busy only in EVAL; DONE without start returns to IDLE after one cycle.
- REQ-020 SHALL ignore start while in EVAL; x,y changes during EVAL SHALL NOT affect the result.
- REQ-021 SHALL make the start-edge to done-high latency exactly 2*GATES_NO cycles (32 for LEVELS=5).

Reset
- REQ-022 SHALL, on rst_n low at any time including mid-EVAL, immediately force state IDLE, busy=0, done=0, z=0, and x_reg, y_reg, buf and counters to 0.
- REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
- REQ-024 SHALL, with TREE_SEQ_ABORT_EN defined, add input abort (1 bit); abort=1 in EVAL SHALL return to IDLE on the next edge with no done pulse and z unchanged; abort SHALL be ignored in other states.
- REQ-025 SHALL, without TREE_SEQ_ABORT_EN, have no abort port and identical behaviour otherwise.

Structure
- REQ-026 SHALL place state encoding (IDLE/EVAL/DONE), operator constants (OP_OR, OP_AND) and the level-to-operator function in shared package tree_seq_pkg.
- REQ-027 SHALL implement the shared gate as sub-module tree_seq_alu: combinational, inputs a, b, op; output c.

Verification (LEVELS=5)
- REQ-028 SHALL check: reset, then x=16'hFFFF, y=0, start pulse -> busy high 31 cycles, done high exactly 32 cycles after start edge, z=1.
- REQ-029 SHALL check: x=16'h000F, y=0 -> z=0; then x=16'h00FF, y=0 -> z=1.
- REQ-030 SHALL check: start during EVAL plus x,y toggled mid-run -> single done, result from originally captured operands.
- REQ-031 SHALL check: start asserted in DONE cycle -> immediate re-entry to EVAL, second done 32 cycles later, no IDLE gap.
- REQ-032 SHALL check: rst_n low at cycle 10 of EVAL -> busy=0, done=0, z=0 immediately; no done afterwards.
- REQ-033 SHALL check, with TREE_SEQ_ABORT_EN: abort at cycle 5 of EVAL after a prior z=1 result -> IDLE next edge, no done, z stays 1.
